mux_barrido: RTL

- Parametrised N-channel, W-bit registered multiplexer; next generation of the team's 2:1 single-bit mux.
- Two modes:
  - Manual: an external select chooses the channel.
  - Scan: an internal prescaler and channel counter step through all channels in turn, time-division style, for display or readout scanning.
- Sits between parallel data sources and a single shared W-bit consumer. Reports which channel is currently presented and pulses at each scan wrap.

---
 rtl/mux_barrido_pkg.sv | 10 +
 rtl/mux_barrido_contador_mod.sv | 30 +++
 rtl/mux_barrido.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mux_barrido_pkg.sv
// Shared types for the scanning multiplexer.
package mux_barrido_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } estado_t;

endpackage

// File: rtl/mux_barrido_contador_mod.sv
// Modulo-M up-counter with enable, synchronous clear and terminal-count flag.
// The wrap is an explicit compare against M-1, so M need not be a power of 2.
module contador_mod #(
  parameter int M  = 4,
  parameter int CW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(M - 1);

  assign tc = (cnt == LAST);

  // Count 0..M-1 while enabled; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux_barrido.sv
// N-channel, W-bit registered multiplexer with manual select and a
// time-division scan mode driven by a prescaler and a channel counter.
//
//   state     | meaning
//   ST_IDLE   | en low: everything frozen, wrap low
//   ST_MANUAL | q/ch follow sel_in with one cycle of latency
//   ST_SCAN   | channels presented in turn, PRESC cycles each
module mux_barrido
  import mux_barrido_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int PRESC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel_in,
  input  logic [N*W-1:0]       d_in,
  output logic [W-1:0]         q,
  output logic [$clog2(N)-1:0] ch,
  output logic                 q_valid,
  output logic                 wrap
);

  localparam int SELW = $clog2(N);
  localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1;

  estado_t          estado;
  logic             entry;
  logic             run;
  logic             cnt_clr;
  logic             presc_tc;
  logic [PW-1:0]    presc_cnt_unused;
  logic             chan_tc;
  logic [SELW-1:0]  chan_cnt;
  logic [SELW-1:0]  ch_scan_nxt;
  logic [SELW-1:0]  idx;
  logic [W-1:0]     data_sel;
  logic             sel_ok;

  // Any edge in scan mode that was not already scanning restarts at channel 0.
  assign entry   = en & mode & (estado != ST_SCAN);
  assign run     = en & mode & (estado == ST_SCAN);
  assign cnt_clr = en & (~mode | entry);

  contador_mod #(.M(PRESC), .CW(PW)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (cnt_clr),
    .cnt   (presc_cnt_unused),
    .tc    (presc_tc)
  );

  contador_mod #(.M(N), .CW(SELW)) u_canal (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run & presc_tc),
    .clr   (cnt_clr),
    .cnt   (chan_cnt),
    .tc    (chan_tc)
  );

  // Channel the scan will present after this edge.
  always_comb begin
    ch_scan_nxt = chan_cnt;
    if (entry) begin
      ch_scan_nxt = '0;
    end else if (presc_tc) begin
      ch_scan_nxt = chan_tc ? '0 : chan_cnt + SELW'(1);
    end
  end

  assign idx = mode ? ch_scan_nxt : sel_in;

  // Data mux; indices at or above N select nothing and flag sel_ok low.
  always_comb begin
    data_sel = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (idx == SELW'(k)) begin
        data_sel = d_in[k*W +: W];
        sel_ok   = 1'b1;
      end
    end
  end

  // State register and registered output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= ST_IDLE;
      q       <= '0;
      ch      <= '0;
      q_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (!en) begin
      estado <= ST_IDLE;
      wrap   <= 1'b0;
    end else if (!mode) begin
      estado <= ST_MANUAL;
      wrap   <= 1'b0;
      if (sel_ok) begin
        ch      <= sel_in;
        q       <= data_sel;
        q_valid <= 1'b1;
      end else begin
        q       <= '0;
        q_valid <= 1'b0;
      end
    end else begin
      estado  <= ST_SCAN;
      ch      <= ch_scan_nxt;
      q       <= data_sel;
      q_valid <= 1'b1;
      wrap    <= run & presc_tc & chan_tc;
    end
  end

endmodule
